// File: rtl/store_set_update_if.sv
// Violation-report intake plus SSIT access and LFST flush signals for the store-set sequencer.
// The master side is the sequencer; the slave side is the LSU / SSIT / LFST environment.
interface store_set_update_if #(
  parameter int unsigned SSIT_IDX_W = 10,
  parameter int unsigned SET_ID_W   = 6
);
  logic                  viol_valid;
  logic                  viol_ready;
  logic [SSIT_IDX_W-1:0] viol_load_pc;
  logic [SSIT_IDX_W-1:0] viol_store_pc;
  logic                  ssit_rd_en;
  logic [SSIT_IDX_W-1:0] ssit_rd_addr;
  logic [SET_ID_W-1:0]   ssit_rd_data;
  logic                  ssit_wr_en;
  logic [SSIT_IDX_W-1:0] ssit_wr_addr;
  logic [SET_ID_W-1:0]   ssit_wr_data;
  logic                  lfst_flush;
  logic                  busy;
  logic                  clearing;

  modport master (
    input  viol_valid, viol_load_pc, viol_store_pc, ssit_rd_data,
    output viol_ready, ssit_rd_en, ssit_rd_addr, ssit_wr_en, ssit_wr_addr, ssit_wr_data,
           lfst_flush, busy, clearing
  );

  modport slave (
    output viol_valid, viol_load_pc, viol_store_pc, ssit_rd_data,
    input  viol_ready, ssit_rd_en, ssit_rd_addr, ssit_wr_en, ssit_wr_addr, ssit_wr_data,
           lfst_flush, busy, clearing
  );
endinterface

// File: rtl/store_set_update_ctrl.sv
// Store-set predictor trainer: buffers violation reports, merges load/store into one store set
// via SSIT read-modify-write, and periodically zeroes the SSIT and flushes the LFST.
module store_set_update_ctrl #(
  parameter int unsigned SSIT_IDX_W     = 10,
  parameter int unsigned SET_ID_W       = 6,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CLEAR_INTERVAL = 100000,
  parameter int unsigned CLEAR_CNT_W    = 17
) (
  input logic                clk,
  input logic                rst,
  store_set_update_if.master bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StRdStore, StEval, StWr2, StClear} state_e;

  // Violation FIFO
  logic [SSIT_IDX_W-1:0] fifo_ld_q [FIFO_DEPTH];
  logic [SSIT_IDX_W-1:0] fifo_st_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  full, empty, push, pop;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.viol_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ld_q[wr_ptr_q] <= bus.viol_load_pc;
      fifo_st_q[wr_ptr_q] <= bus.viol_store_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Sequencer state
  state_e                state_q, state_d;
  logic [SSIT_IDX_W-1:0] ld_q, ld_d, st_q, st_d, clr_addr_q, clr_addr_d;
  logic [SET_ID_W-1:0]   l_q, l_d, alloc_q, alloc_d, alloc_next, s_id;
  logic [CLEAR_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pending_q, pending_d, expire, clear_done;
  logic                  rd_en, wr_en, flush;
  logic [SSIT_IDX_W-1:0] rd_addr, wr_addr;
  logic [SET_ID_W-1:0]   wr_data;

  assign s_id       = bus.ssit_rd_data;
  // IDs 0 and 1 are reserved, so allocation cycles through 2..max.
  assign alloc_next = (alloc_q == '1) ? SET_ID_W'(2) : alloc_q + SET_ID_W'(1);
  assign expire     = (cnt_q == CLEAR_CNT_W'(CLEAR_INTERVAL - 1));

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    st_d       = st_q;
    l_d        = l_q;
    alloc_d    = alloc_q;
    clr_addr_d = clr_addr_q;
    pop        = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    flush      = 1'b0;
    clear_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          clr_addr_d = '0;
          state_d    = StClear;
        end else if (!empty) begin
          pop     = 1'b1;
          ld_d    = fifo_ld_q[rd_ptr_q];
          st_d    = fifo_st_q[rd_ptr_q];
          rd_en   = 1'b1;
          rd_addr = fifo_ld_q[rd_ptr_q];
          state_d = StRdStore;
        end
      end
      StRdStore: begin
        l_d     = s_id;
        rd_en   = 1'b1;
        rd_addr = st_q;
        state_d = StEval;
      end
      StEval: begin
        state_d = StIdle;
        if (l_q == '0 && s_id == '0) begin
          wr_en   = 1'b1;
          wr_addr = ld_q;
          wr_data = alloc_q;
          state_d = StWr2;
        end else if (s_id == '0 || (l_q != '0 && l_q < s_id)) begin
          wr_en   = 1'b1;
          wr_addr = st_q;
          wr_data = l_q;
        end else if (l_q != s_id) begin
          wr_en   = 1'b1;
          wr_addr = ld_q;
          wr_data = s_id;
        end
      end
      StWr2: begin
        wr_en   = 1'b1;
        wr_addr = st_q;
        wr_data = alloc_q;
        alloc_d = alloc_next;
        state_d = StIdle;
      end
      StClear: begin
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        clr_addr_d = clr_addr_q + SSIT_IDX_W'(1);
        if (clr_addr_q == '1) begin
          flush      = 1'b1;
          clear_done = 1'b1;
          alloc_d    = SET_ID_W'(2);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Exit from a sweep wins over a coincident expiry so only one clear is ever outstanding.
  always_comb begin
    cnt_d     = expire ? '0 : cnt_q + CLEAR_CNT_W'(1);
    pending_d = clear_done ? 1'b0 : (expire ? 1'b1 : pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ld_q       <= '0;
      st_q       <= '0;
      l_q        <= '0;
      alloc_q    <= SET_ID_W'(2);
      clr_addr_q <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      st_q       <= st_d;
      l_q        <= l_d;
      alloc_q    <= alloc_d;
      clr_addr_q <= clr_addr_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Strobes are masked during reset so an abandoned sequence issues no further accesses.
  assign bus.ssit_rd_en   = rd_en && !rst;
  assign bus.ssit_rd_addr = rd_addr;
  assign bus.ssit_wr_en   = wr_en && !rst;
  assign bus.ssit_wr_addr = wr_addr;
  assign bus.ssit_wr_data = wr_data;
  assign bus.lfst_flush   = flush && !rst;
  assign bus.viol_ready   = !full;
  assign bus.busy         = (state_q != StIdle) || !empty;
  assign bus.clearing     = (state_q == StClear);
endmodule

// File: doc/store_set_update_ctrl.md
Name: store_set_update_ctrl

Overview:
Sequencer that trains the store-set dependence predictor.
- Accepts memory-order violation reports (load PC index, store PC index) from the LSU and buffers them in a small FIFO.
- Runs a read-modify-write FSM on the store set ID table (SSIT) to merge the load and store into one store set.
- Periodically sweeps the SSIT to zero and flushes the last fetch store table (LFST), so stale sets age out.
- Sits beside the SSIT/LFST pair; it owns the SSIT write port and the LFST flush.

Parameters:
SSIT_IDX_W, 10, SSIT index width; the SSIT has 2^SSIT_IDX_W entries.
SET_ID_W, 6, store set ID width; equals the LFST index width.
FIFO_DEPTH, 4, violation FIFO entries (power of two).
CLEAR_INTERVAL, 100000, cycles between SSIT clear sweeps.
CLEAR_CNT_W, 17, interval counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
viol_valid  in  1  violation report valid
viol_ready  out  1  FIFO can accept; equals !fifo_full
viol_load_pc  in  SSIT_IDX_W  SSIT index of the violating load
viol_store_pc  in  SSIT_IDX_W  SSIT index of the conflicting store
ssit_rd_en  out  1  SSIT read request
ssit_rd_addr  out  SSIT_IDX_W  SSIT read index
ssit_rd_data  in  SET_ID_W  SSIT read data, valid the cycle after ssit_rd_en
ssit_wr_en  out  1  SSIT write strobe
ssit_wr_addr  out  SSIT_IDX_W  SSIT write index
ssit_wr_data  out  SET_ID_W  SSIT write data
lfst_flush  out  1  one-cycle pulse; clears every LFST entry
busy  out  1  FSM not in IDLE, or FIFO not empty
clearing  out  1  FSM in CLEAR

Behaviour:
- Reset:
  - FSM goes to IDLE and the FIFO empties.
  - alloc_id=2, interval counter=0, clear_pending=0.
  - ssit_rd_en, ssit_wr_en, lfst_flush, busy and clearing are 0; viol_ready is 1.
  - rst asserted mid-operation abandons any in-flight sequence with no further writes.
- FIFO:
  - A push happens when viol_valid && viol_ready.
  - Push and pop may occur in the same cycle.
  - When full, the report is not accepted; the source holds it.
  - Entries pop in order.
- Reserved set IDs: 0 means no set. 1 is the LFST "always dependent" ID; it is never allocated but is treated as an ordinary nonzero ID when read.
- IDLE:
  - If clear_pending, go to CLEAR (priority over the FIFO).
  - Otherwise, if the FIFO is non-empty, pop the head, latch the PCs, drive ssit_rd_en with addr=load_pc, and go to RD_STORE.
- RD_STORE: capture L=ssit_rd_data, drive ssit_rd_en with addr=store_pc, and go to EVAL.
- EVAL: capture S=ssit_rd_data, then act on (L, S):
  - L=0, S=0: write ssit[load_pc]=alloc_id and go to WR2. WR2 writes ssit[store_pc]=alloc_id, increments alloc_id, and returns to IDLE.
  - L≠0, S=0: write ssit[store_pc]=L and go to IDLE.
  - L=0, S≠0: write ssit[load_pc]=S and go to IDLE.
  - L=S≠0: no write; go to IDLE.
  - L≠S, both ≠0: winner=min(L,S); write winner into the PC holding the larger ID; go to IDLE.
- Latency: a report accepted at cycle t into an empty FIFO, with the FSM in IDLE and no clear pending, gives rd load at t+1, rd store at t+2, first write at t+3, optional second write at t+4.
- alloc_id: increments modulo the range 2..2^SET_ID_W-1; after 2^SET_ID_W-1 it wraps to 2.
- Interval counter:
  - Free-running; at CLEAR_INTERVAL-1 it sets clear_pending and restarts at 0.
  - A second expiry while pending or clearing is absorbed; only one clear is outstanding.
- CLEAR:
  - Writes 0 to SSIT addresses 0..2^SSIT_IDX_W-1, one per cycle, ascending.
  - lfst_flush pulses in the same cycle as the last write.
  - On exit, alloc_id=2 and clear_pending=0; return to IDLE.
  - FIFO pushes continue during CLEAR and are processed afterwards against the cleared table.
- Only one SSIT access (read or write) is issued per cycle. Aliased load_pc==store_pc needs no special case.

Test Plan:
Use SSIT_IDX_W=4, SET_ID_W=3, FIFO_DEPTH=4, CLEAR_INTERVAL=64 with a behavioural SSIT model.
- SSIT all 0; violation (load=3, store=5) -> reads at 3 then 5; writes ssit[3]=2 at t+3 and ssit[5]=2 at t+4; alloc_id becomes 3.
- ssit[5]=2, ssit[7]=0; violation (load=7, store=5) -> single write ssit[7]=2 at t+3; no WR2 cycle.
- ssit[3]=4, ssit[5]=2; violation (3,5) -> single write ssit[3]=2. With ssit[3]=ssit[5]=4 -> no write.
- Seven successive fresh-pair violations (all L=S=0) -> allocated IDs 2,3,4,5,6,7,2; ID 0 and ID 1 are never written by allocation.
- Six back-to-back reports with viol_valid held, FSM stalled by a preceding report -> viol_ready drops once 4 entries are buffered; all 6 are eventually accepted and processed in arrival order.
- Run to cycle 63 -> CLEAR writes 0 to addresses 0..15 over 16 cycles; lfst_flush is high only with the addr 15 write; clearing=1 throughout. A report arriving during CLEAR is processed afterwards and gets alloc_id=2. rst asserted mid-CLEAR -> no further writes; FSM in IDLE.
